// File: rtl/rs_pipeline_pkg.sv
//------------------------------------------------------------------------------
// rs_pipeline_pkg : shared types and helpers for the relay-station tail FIFO
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rs_pipeline_pkg;

  localparam int RS_DEFAULT_DEPTH = 64;
  localparam int RS_DEFAULT_PTR_W = $clog2(RS_DEFAULT_DEPTH);
  localparam int RS_DEFAULT_CNT_W = RS_DEFAULT_PTR_W + 1;

  typedef struct packed {
    logic empty_n;
    logic full_n;
    logic overflow;
  } rs_fifo_status_t;

  // Beats still in flight after the stop flag: forward plus return path.
  function automatic int rs_grace(input int level);
    return 2 * level;
  endfunction

  function automatic int rs_ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rs_tail_fifo_mem.sv
//------------------------------------------------------------------------------
// rs_tail_fifo_mem : DEPTH x DATA_WIDTH storage, sync write / async read
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rs_tail_fifo_mem
  import rs_pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int ADDR_W     = rs_ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Combinational read keeps the head word visible without a read cycle.
  assign rd_data = mem_q[rd_addr];

endmodule

`default_nettype wire

// File: rtl/rs_pipeline_tail_fifo.sv
//------------------------------------------------------------------------------
// rs_pipeline_tail_fifo : FWFT tail FIFO for a pipelined relay-station channel
// Optional statistics ports enabled by RS_TAIL_FIFO_STATS_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rs_pipeline_tail_fifo
  import rs_pipeline_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 64,
  parameter int PIPELINE_LEVEL = 12,
  parameter int GRACE          = rs_grace(PIPELINE_LEVEL)
) (
  input  logic                    clk,
  input  logic                    ap_rst_n,
  input  logic [DATA_WIDTH-1:0]   if_din,
  input  logic                    if_write,
  output logic                    if_full_n,
  output logic [DATA_WIDTH-1:0]   if_dout,
  output logic                    if_empty_n,
  input  logic                    if_read,
  output logic                    overflow
`ifdef RS_TAIL_FIFO_STATS_EN
  ,
  output logic [$clog2(DEPTH):0]  stat_max_count,
  output logic [15:0]             stat_drop_cnt
`endif
);

  localparam int PTR_W = rs_ptr_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] FULL_THR_C = CNT_W'(DEPTH - GRACE - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  rs_fifo_status_t  status_q, status_d;

  logic pop;
  logic push;
  logic drop;

  always_comb begin
    pop  = if_read & status_q.empty_n;
    // A pop in the same cycle frees the slot, so a write at full still lands.
    push = if_write & ((count_q < DEPTH_C) | pop);
    drop = if_write & ~push;

    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    status_d.empty_n  = (count_d != '0);
    status_d.full_n   = (count_d <= FULL_THR_C);
    status_d.overflow = status_q.overflow | drop;
  end

  always_ff @(posedge clk) begin
    if (!ap_rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      status_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      status_q <= status_d;
    end
  end

  rs_tail_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (if_din),
    .rd_addr (rd_ptr_q),
    .rd_data (if_dout)
  );

  assign if_full_n  = status_q.full_n;
  assign if_empty_n = status_q.empty_n;
  assign overflow   = status_q.overflow;

`ifdef RS_TAIL_FIFO_STATS_EN
  logic [CNT_W-1:0] stat_max_q, stat_max_d;
  logic [15:0]      stat_drop_q, stat_drop_d;

  always_comb begin
    stat_max_d  = (count_d > stat_max_q) ? count_d : stat_max_q;
    stat_drop_d = (drop && (stat_drop_q != 16'hFFFF)) ? stat_drop_q + 16'd1 : stat_drop_q;
  end

  always_ff @(posedge clk) begin
    if (!ap_rst_n) begin
      stat_max_q  <= '0;
      stat_drop_q <= '0;
    end else begin
      stat_max_q  <= stat_max_d;
      stat_drop_q <= stat_drop_d;
    end
  end

  assign stat_max_count = stat_max_q;
  assign stat_drop_cnt  = stat_drop_q;
`else
  // Statistics build option disabled: no watermark or drop counter.
`endif

endmodule

`default_nettype wire

// File: tb/tb_rs_pipeline_tail_fifo.sv
//------------------------------------------------------------------------------
// tb_rs_pipeline_tail_fifo : directed + scoreboard bench for the tail FIFO
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_rs_pipeline_tail_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int PL    = 12;
  localparam int GRACE = 24;

  logic          clk = 1'b0;
  logic          ap_rst_n;
  logic [DW-1:0] if_din;
  logic          if_write;
  logic          if_full_n;
  logic [DW-1:0] if_dout;
  logic          if_empty_n;
  logic          if_read;
  logic          overflow;
`ifdef RS_TAIL_FIFO_STATS_EN
  logic [6:0]    stat_max_count;
  logic [15:0]   stat_drop_cnt;
`endif

  always #5 clk = ~clk;

  rs_pipeline_tail_fifo #(
    .DATA_WIDTH     (DW),
    .DEPTH          (DEPTH),
    .PIPELINE_LEVEL (PL),
    .GRACE          (GRACE)
  ) dut (
    .clk            (clk),
    .ap_rst_n       (ap_rst_n),
    .if_din         (if_din),
    .if_write       (if_write),
    .if_full_n      (if_full_n),
    .if_dout        (if_dout),
    .if_empty_n     (if_empty_n),
    .if_read        (if_read),
    .overflow       (overflow)
`ifdef RS_TAIL_FIFO_STATS_EN
    ,
    .stat_max_count (stat_max_count),
    .stat_drop_cnt  (stat_drop_cnt)
`endif
  );

  typedef struct {
    logic        rst_n;
    logic        wr;
    logic [31:0] din;
    logic        rd;
    logic        exp_empty_n;
    logic        exp_full_n;
    logic        exp_ovf;
    logic        chk_dout;
    logic [31:0] exp_dout;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic w, input logic [31:0] d, input logic rd,
                              input logic e, input logic f, input logic o,
                              input logic cd, input logic [31:0] ed);
    vec_t v;
    v.rst_n = r; v.wr = w; v.din = d; v.rd = rd;
    v.exp_empty_n = e; v.exp_full_n = f; v.exp_ovf = o;
    v.chk_dout = cd; v.exp_dout = ed;
    return v;
  endfunction

  vec_t vecs[13];
  logic [31:0] mq[$];
  logic        movf;

  initial begin
    ap_rst_n = 1'b0;
    if_write = 1'b0;
    if_read  = 1'b0;
    if_din   = '0;

    // Short directed table: reset, single beat, count=1 push+pop, empty pop.
    vecs[0]  = mk(0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0);
    vecs[1]  = mk(0, 1, 32'h11,       0, 0, 0, 0, 0, 32'h0);
    vecs[2]  = mk(1, 0, 32'h0,        0, 0, 1, 0, 0, 32'h0);
    vecs[3]  = mk(1, 1, 32'hDEADBEEF, 0, 1, 1, 0, 1, 32'hDEADBEEF);
    vecs[4]  = mk(1, 0, 32'h0,        1, 0, 1, 0, 0, 32'h0);
    vecs[5]  = mk(1, 1, 32'hA1,       0, 1, 1, 0, 1, 32'hA1);
    vecs[6]  = mk(1, 1, 32'hA2,       1, 1, 1, 0, 1, 32'hA2);
    vecs[7]  = mk(1, 0, 32'h0,        1, 0, 1, 0, 0, 32'h0);
    vecs[8]  = mk(1, 0, 32'h0,        1, 0, 1, 0, 0, 32'h0);
    vecs[9]  = mk(1, 1, 32'hB1,       0, 1, 1, 0, 1, 32'hB1);
    vecs[10] = mk(1, 1, 32'hB2,       0, 1, 1, 0, 1, 32'hB1);
    vecs[11] = mk(1, 0, 32'h0,        1, 1, 1, 0, 1, 32'hB2);
    vecs[12] = mk(1, 0, 32'h0,        1, 0, 1, 0, 0, 32'h0);

    for (int i = 0; i < 13; i++) begin
      ap_rst_n = vecs[i].rst_n;
      if_write = vecs[i].wr;
      if_din   = vecs[i].din;
      if_read  = vecs[i].rd;
      cyc();
      chk($sformatf("vec%0d empty_n", i), {31'b0, if_empty_n}, {31'b0, vecs[i].exp_empty_n});
      chk($sformatf("vec%0d full_n", i),  {31'b0, if_full_n},  {31'b0, vecs[i].exp_full_n});
      chk($sformatf("vec%0d overflow", i), {31'b0, overflow},  {31'b0, vecs[i].exp_ovf});
      if (vecs[i].chk_dout) chk($sformatf("vec%0d dout", i), if_dout, vecs[i].exp_dout);
    end
    if_write = 1'b0;
    if_read  = 1'b0;

    // Fill: stop flag drops as count reaches DEPTH-GRACE, then absorb GRACE more.
    for (int i = 0; i < 39; i++) begin
      if_write = 1'b1; if_din = 32'h1000_0000 + i;
      cyc();
    end
    chk("fill39 full_n", {31'b0, if_full_n}, 32'd1);
    if_din = 32'h1000_0000 + 39;
    cyc();
    chk("fill40 full_n", {31'b0, if_full_n}, 32'd0);
    for (int i = 40; i < 64; i++) begin
      if_din = 32'h1000_0000 + i;
      cyc();
    end
    if_write = 1'b0;
    cyc();
    chk("full64 full_n", {31'b0, if_full_n}, 32'd0);
    chk("full64 overflow", {31'b0, overflow}, 32'd0);
    chk("full64 head", if_dout, 32'h1000_0000);

    // Write + read at full: accepted, no overflow.
    if_write = 1'b1; if_read = 1'b1; if_din = 32'h2000_0000;
    cyc();
    chk("full rw overflow", {31'b0, overflow}, 32'd0);
    chk("full rw head", if_dout, 32'h1000_0001);

    // Write without read at full: dropped, sticky overflow.
    if_read = 1'b0; if_din = 32'h3000_0000;
    cyc();
    if_write = 1'b0;
    chk("drop overflow", {31'b0, overflow}, 32'd1);
    cyc();
    chk("drop overflow sticky", {31'b0, overflow}, 32'd1);
`ifdef RS_TAIL_FIFO_STATS_EN
    chk("stat_drop_cnt", {16'b0, stat_drop_cnt}, 32'd1);
    chk("stat_max_count", {25'b0, stat_max_count}, 32'd64);
`endif

    // Drain: order preserved, beat accepted at full sits at the tail.
    if_read = 1'b1;
    for (int k = 0; k < 64; k++) begin
      chk($sformatf("drain%0d dout", k), if_dout, (k < 63) ? 32'h1000_0001 + k : 32'h2000_0000);
      cyc();
    end
    if_read = 1'b0;
    chk("drained empty_n", {31'b0, if_empty_n}, 32'd0);
    chk("drained full_n", {31'b0, if_full_n}, 32'd1);
    chk("drained overflow", {31'b0, overflow}, 32'd1);

    // Random traffic against a queue scoreboard.
    ap_rst_n = 1'b0;
    cyc();
    ap_rst_n = 1'b1;
    cyc();
    chk("rst clears overflow", {31'b0, overflow}, 32'd0);
    mq.delete();
    movf = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      logic p_pop, p_push;
      if_write = ($urandom_range(0, 99) < ((n < 3000) ? 70 : 50));
      if_read  = ($urandom_range(0, 99) < ((n < 3000) ? 35 : 50));
      if_din   = $urandom;
      @(posedge clk);
      p_pop  = if_read && (mq.size() != 0);
      p_push = if_write && ((mq.size() < DEPTH) || p_pop);
      if (p_pop) void'(mq.pop_front());
      if (p_push) mq.push_back(if_din);
      if (if_write && !p_push) movf = 1'b1;
      #1;
      chk("rand empty_n", {31'b0, if_empty_n}, {31'b0, (mq.size() != 0)});
      chk("rand full_n", {31'b0, if_full_n}, {31'b0, (mq.size() <= DEPTH - GRACE - 1)});
      chk("rand overflow", {31'b0, overflow}, {31'b0, movf});
      if (mq.size() != 0) chk("rand dout", if_dout, mq[0]);
    end

    // Reset mid-burst: writes during reset are ignored.
    ap_rst_n = 1'b0; if_write = 1'b1; if_read = 1'b0;
    cyc();
    chk("midrst empty_n", {31'b0, if_empty_n}, 32'd0);
    chk("midrst full_n", {31'b0, if_full_n}, 32'd0);
    chk("midrst overflow", {31'b0, overflow}, 32'd0);
    cyc();
    chk("midrst hold overflow", {31'b0, overflow}, 32'd0);
`ifdef RS_TAIL_FIFO_STATS_EN
    chk("midrst stat_max", {25'b0, stat_max_count}, 32'd0);
    chk("midrst stat_drop", {16'b0, stat_drop_cnt}, 32'd0);
`endif
    ap_rst_n = 1'b1; if_write = 1'b0;
    cyc();
    chk("post rst full_n", {31'b0, if_full_n}, 32'd1);
    chk("post rst empty_n", {31'b0, if_empty_n}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
